// File: rtl/gray_code_counter_if.sv
// Purpose: bundles the counter controls/outputs and the Gray decoder request/result.
// Latency: n/a (wires only); clk_i/rst_n_i stay plain ports on the counter itself.
// Backpressure: none; the decoder accepts a request every cycle.
//
// Signals
//   en_i, up_i, load_i, load_val_i : counter enable, direction, load strobe, load value
//   bin_o, gray_o, wrap_o          : registered count, its Gray code, wrap/saturate pulse
//   conv_vld_i, conv_gray_i        : decode request valid and Gray word
//   conv_vld_o, conv_bin_o         : decode result valid and binary word
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);
  logic             en_i;
  logic             up_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic             wrap_o;
  logic             conv_vld_i;
  logic [WIDTH-1:0] conv_gray_i;
  logic             conv_vld_o;
  logic [WIDTH-1:0] conv_bin_o;

  // master: the block driving requests (bench / upstream logic)
  modport master (
    output en_i, up_i, load_i, load_val_i, conv_vld_i, conv_gray_i,
    input  bin_o, gray_o, wrap_o, conv_vld_o, conv_bin_o
  );

  // slave: the counter/decoder itself
  modport slave (
    input  en_i, up_i, load_i, load_val_i, conv_vld_i, conv_gray_i,
    output bin_o, gray_o, wrap_o, conv_vld_o, conv_bin_o
  );
endinterface

// File: rtl/gray_code_counter.sv
// Purpose: up/down binary counter with registered Gray output, plus an independent Gray-to-binary decoder.
// Latency: count/Gray/wrap update 1 cycle after the controlling edge; decoder result 1 cycle after request.
// Backpressure: none; counter steps whenever enabled, decoder takes a new word every cycle.
//
// Ports
//   clk_i   : single clock, rising edge
//   rst_n_i : asynchronous active-low reset, clears every output register immediately
//   bus     : gray_code_counter_if.slave (counter controls/outputs and decoder request/result)
// Parameters
//   WIDTH   : counter and decoder width, 2..16
//   WRAP    : 1 = modulo count, 0 = saturate at all-ones / zero
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input logic                clk_i,
  input logic                rst_n_i,
  gray_code_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  logic             conv_vld_q;
  logic [WIDTH-1:0] conv_bin_q;
  logic [WIDTH-1:0] conv_dec;

  // Next count. Load beats enable; a step that would cross a terminal value
  // either rolls over (WRAP=1) or is blocked (WRAP=0), and both raise wrap.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (bus.load_i) begin
      bin_nxt = bus.load_val_i;
    end else if (bus.en_i) begin
      if (bus.up_i) begin
        if (bin_q == ALL_ONES) begin
          wrap_nxt = 1'b1;
          bin_nxt  = (WRAP != 0) ? '0 : bin_q;
        end else begin
          bin_nxt = bin_q + ONE;
        end
      end else begin
        if (bin_q == '0) begin
          wrap_nxt = 1'b1;
          bin_nxt  = (WRAP != 0) ? ALL_ONES : bin_q;
        end else begin
          bin_nxt = bin_q - ONE;
        end
      end
    end
  end

  // Gray is derived from the next binary value and registered alongside it,
  // so the two outputs always describe the same count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= bin_nxt ^ (bin_nxt >> 1);
      wrap_q <= wrap_nxt;
    end
  end

  // bin[i] is the XOR of all Gray bits at or above i, which is the
  // MSB-first recurrence bin[i] = bin[i+1] ^ gray[i] written without a chain.
  always_comb begin
    conv_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      conv_dec[i] = ^(bus.conv_gray_i >> i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      conv_vld_q <= 1'b0;
      conv_bin_q <= '0;
    end else begin
      conv_vld_q <= bus.conv_vld_i;
      if (bus.conv_vld_i) begin
        conv_bin_q <= conv_dec;
      end
    end
  end

  assign bus.bin_o      = bin_q;
  assign bus.gray_o     = gray_q;
  assign bus.wrap_o     = wrap_q;
  assign bus.conv_vld_o = conv_vld_q;
  assign bus.conv_bin_o = conv_bin_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Purpose: directed bench for gray_code_counter, one modulo instance and one saturating instance.
// Latency: outputs checked every falling edge against an arithmetic model, plus literal checkpoints.
// Backpressure: none; stimulus is a fixed cycle-by-cycle sequence.
module tb_gray_code_counter;

  localparam int W = 4;
  localparam int N = 16;

  logic clk_i = 1'b0;
  logic rst_n_i;

  always #5 clk_i = ~clk_i;

  gray_code_counter_if #(.WIDTH(W)) bus_w ();
  gray_code_counter_if #(.WIDTH(W)) bus_s ();

  gray_code_counter #(.WIDTH(W), .WRAP(1)) dut_w (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_w)
  );

  gray_code_counter #(.WIDTH(W), .WRAP(0)) dut_s (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_s)
  );

  int checks = 0;
  int errors = 0;

  // Gray code of index i, written out by hand.
  int gseq [N] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by search: the binary value whose Gray code matches.
  function automatic int gray_decode(input int g);
    for (int v = 0; v < N; v++) begin
      if (gray_of(v) == g) return v;
    end
    return -1;
  endfunction

  task automatic adv(input int b, input bit modulo, input logic en, input logic up,
                     input logic ld, input int lv,
                     output int nb, output logic w, output logic stepped);
    int t;
    nb = b; w = 1'b0; stepped = 1'b0;
    if (ld) begin
      nb = lv;
    end else if (en) begin
      t = up ? b + 1 : b - 1;
      if (t < 0 || t > N - 1) begin
        w  = 1'b1;
        nb = modulo ? (t + N) % N : b;
      end else begin
        nb = t;
      end
      stepped = (nb != b);
    end
  endtask

  int   m_bin_w = 0, m_bin_s = 0, m_cbin = 0;
  logic m_wrap_w = 0, m_wrap_s = 0, m_step_w = 0, m_step_s = 0, m_cvld = 0;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_bin_w = 0; m_bin_s = 0; m_wrap_w = 0; m_wrap_s = 0;
      m_step_w = 0; m_step_s = 0; m_cvld = 0; m_cbin = 0;
    end else begin
      adv(m_bin_w, 1'b1, bus_w.en_i, bus_w.up_i, bus_w.load_i, int'(bus_w.load_val_i),
          m_bin_w, m_wrap_w, m_step_w);
      adv(m_bin_s, 1'b0, bus_s.en_i, bus_s.up_i, bus_s.load_i, int'(bus_s.load_val_i),
          m_bin_s, m_wrap_s, m_step_s);
      m_cvld = bus_w.conv_vld_i;
      if (bus_w.conv_vld_i) m_cbin = gray_decode(int'(bus_w.conv_gray_i));
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [W-1:0] prev_gw = '0, prev_gs = '0;

  always @(negedge clk_i) begin
    chk("w_bin",  bus_w.bin_o,  m_bin_w);
    chk("w_gray", bus_w.gray_o, gray_of(m_bin_w));
    chk("w_wrap", bus_w.wrap_o, m_wrap_w);
    chk("s_bin",  bus_s.bin_o,  m_bin_s);
    chk("s_gray", bus_s.gray_o, gray_of(m_bin_s));
    chk("s_wrap", bus_s.wrap_o, m_wrap_s);
    chk("conv_vld", bus_w.conv_vld_o, m_cvld);
    chk("conv_bin", bus_w.conv_bin_o, m_cbin);
    if (m_step_w) chk("w_hamming", $countones(bus_w.gray_o ^ prev_gw), 1);
    if (m_step_s) chk("s_hamming", $countones(bus_s.gray_o ^ prev_gs), 1);
    prev_gw = bus_w.gray_o;
    prev_gs = bus_s.gray_o;
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs to both instances, then sit 2 time units past the edge.
  task automatic drive(input logic en, input logic up, input logic ld, input logic [W-1:0] lv,
                       input logic cv, input logic [W-1:0] cg);
    bus_w.en_i = en; bus_w.up_i = up; bus_w.load_i = ld; bus_w.load_val_i = lv;
    bus_w.conv_vld_i = cv; bus_w.conv_gray_i = cg;
    bus_s.en_i = en; bus_s.up_i = up; bus_s.load_i = ld; bus_s.load_val_i = lv;
    bus_s.conv_vld_i = cv; bus_s.conv_gray_i = cg;
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bin"},  bus_w.bin_o | bus_s.bin_o, 0);
    chk({tag, "_gray"}, bus_w.gray_o | bus_s.gray_o, 0);
    chk({tag, "_wrap"}, bus_w.wrap_o | bus_s.wrap_o, 0);
    chk({tag, "_cvld"}, bus_w.conv_vld_o | bus_s.conv_vld_o, 0);
    chk({tag, "_cbin"}, bus_w.conv_bin_o | bus_s.conv_bin_o, 0);
  endtask

  int   s_exp_wrap [3] = '{0, 1, 1};
  int   w_exp_bin  [3] = '{15, 0, 1};
  int   w_exp_wrap [3] = '{0, 1, 0};
  logic [W-1:0] g4;

  initial begin
    rst_n_i = 1'b0;
    bus_w.en_i = 0; bus_w.up_i = 0; bus_w.load_i = 0; bus_w.load_val_i = '0;
    bus_w.conv_vld_i = 0; bus_w.conv_gray_i = '0;
    bus_s.en_i = 0; bus_s.up_i = 0; bus_s.load_i = 0; bus_s.load_val_i = '0;
    bus_s.conv_vld_i = 0; bus_s.conv_gray_i = '0;
    #2;
    chk_all_zero("reset");
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;

    // Full up-count from reset: 16 steps, single wrap on the last.
    for (int i = 0; i < N; i++) begin
      drive(1, 1, 0, '0, 0, '0);
      chk("upcnt_gray", bus_w.gray_o, gseq[(i + 1) % N]);
      chk("upcnt_wrap", bus_w.wrap_o, (i == N - 1) ? 1 : 0);
    end

    // Down-count wrap from 0001.
    drive(0, 0, 1, 4'b0001, 0, '0);
    chk("dn_load", bus_w.bin_o, 1);
    drive(1, 0, 0, '0, 0, '0);
    chk("dn1_bin", bus_w.bin_o, 0);
    chk("dn1_wrap", bus_w.wrap_o, 0);
    drive(1, 0, 0, '0, 0, '0);
    chk("dn2_bin", bus_w.bin_o, 15);
    chk("dn2_gray", bus_w.gray_o, 8);
    chk("dn2_wrap", bus_w.wrap_o, 1);
    chk("dn2_sat_bin", bus_s.bin_o, 0);
    chk("dn2_sat_wrap", bus_s.wrap_o, 1);

    // Saturation at all-ones, compared against the modulo instance.
    drive(0, 1, 1, 4'b1110, 0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, '0, 0, '0);
      chk("sat_bin", bus_s.bin_o, 15);
      chk("sat_wrap", bus_s.wrap_o, s_exp_wrap[i]);
      chk("mod_bin", bus_w.bin_o, w_exp_bin[i]);
      chk("mod_wrap", bus_w.wrap_o, w_exp_wrap[i]);
    end

    // Direction flips every cycle with no bubble (modulo count is at 1).
    drive(1, 0, 0, '0, 0, '0);
    chk("dir_dn", bus_w.bin_o, 0);
    drive(1, 1, 0, '0, 0, '0);
    chk("dir_up", bus_w.bin_o, 1);
    drive(1, 0, 0, '0, 0, '0);
    drive(1, 0, 0, '0, 0, '0);
    chk("dir_wrap_bin", bus_w.bin_o, 15);
    chk("dir_wrap_pulse", bus_w.wrap_o, 1);

    // Hold with enable low.
    drive(0, 1, 0, '0, 0, '0);
    drive(0, 1, 0, '0, 0, '0);
    chk("hold_bin", bus_w.bin_o, 15);
    chk("hold_wrap", bus_w.wrap_o, 0);

    // Load beats enable.
    drive(1, 1, 1, 4'b1010, 0, '0);
    chk("ld_bin", bus_w.bin_o, 10);
    chk("ld_gray", bus_w.gray_o, 15);
    chk("ld_wrap", bus_w.wrap_o, 0);
    chk("ld_sat_bin", bus_s.bin_o, 10);

    // Decoder streaming, counter running alongside.
    for (int i = 0; i < N; i++) begin
      g4 = W'(gseq[i]);
      drive(1, (i % 3) != 0, 0, '0, 1, g4);
      chk("conv_stream_bin", bus_w.conv_bin_o, i);
      chk("conv_stream_vld", bus_w.conv_vld_o, 1);
    end
    drive(0, 0, 0, '0, 0, 4'b0101);
    chk("conv_idle_vld", bus_w.conv_vld_o, 0);
    chk("conv_idle_hold", bus_w.conv_bin_o, 15);

    // Mid-run reset while counting at 0111.
    drive(0, 1, 1, 4'b0110, 1, 4'b0110);
    drive(1, 1, 0, '0, 1, 4'b0011);
    chk("pre_rst_bin", bus_w.bin_o, 7);
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    chk("rel_bin", bus_w.bin_o, 0);
    drive(1, 1, 0, '0, 0, '0);
    chk("restart_bin", bus_w.bin_o, 1);
    chk("restart_gray", bus_w.gray_o, 1);
    drive(0, 0, 0, '0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
